// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: per-channel synchroniser, stability counter,
// registered rise/fall strobes and long-press detection. Channels are independent.
module debounce_bank #(
   parameter int CHANNELS       = 4,
   parameter int DEBOUNCE_LIMIT = 20,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_LIMIT     = 1000
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic [CHANNELS-1:0] i_switch,
   output logic [CHANNELS-1:0] o_filtered,
   output logic [CHANNELS-1:0] o_rise,
   output logic [CHANNELS-1:0] o_fall,
   output logic [CHANNELS-1:0] o_held,
   output logic [CHANNELS-1:0] o_long,
   output logic                o_any_event
);

   localparam int DW = $clog2(DEBOUNCE_LIMIT + 1);
   localparam int HW = $clog2(HOLD_LIMIT + 1);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_LIMIT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LIMIT - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_LIMIT);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [SYNC_STAGES-1:0] sync_reg;
         logic                   s;
         logic [DW-1:0]          deb_cnt_reg, deb_cnt_next;
         logic                   filt_reg, filt_next;
         logic                   rise_reg, rise_next;
         logic                   fall_reg, fall_next;
         logic [HW-1:0]          hold_cnt_reg, hold_cnt_next;
         logic                   held_reg, held_next;
         logic                   long_reg, long_next;

         if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge i_clock) begin
               if (i_reset) begin
                  sync_reg <= '0;
               end else begin
                  sync_reg <= i_switch[gi];
               end
            end
         end else begin : g_sync_chain
            always_ff @(posedge i_clock) begin
               if (i_reset) begin
                  sync_reg <= '0;
               end else begin
                  sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_switch[gi]};
               end
            end
         end

         assign s = sync_reg[SYNC_STAGES-1];

         always_comb begin
            deb_cnt_next  = deb_cnt_reg;
            filt_next     = filt_reg;
            rise_next     = 1'b0;
            fall_next     = 1'b0;
            hold_cnt_next = hold_cnt_reg;
            held_next     = held_reg;
            long_next     = 1'b0;

            // Any cycle agreeing with the accepted level restarts the stability count.
            if (s == filt_reg) begin
               deb_cnt_next = '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
               deb_cnt_next = '0;
               filt_next    = s;
               rise_next    = s;
               fall_next    = ~s;
            end else begin
               deb_cnt_next = deb_cnt_reg + DW'(1);
            end

            // A falling edge wins over a coincident hold-limit crossing: no long press.
            if (!filt_reg || fall_next) begin
               hold_cnt_next = '0;
            end else if (hold_cnt_reg != HOLD_MAX) begin
               hold_cnt_next = hold_cnt_reg + HW'(1);
               if (hold_cnt_reg == HOLD_LAST) begin
                  long_next = 1'b1;
                  held_next = 1'b1;
               end
            end

            if (fall_next) begin
               held_next = 1'b0;
            end
         end

         always_ff @(posedge i_clock) begin
            if (i_reset) begin
               deb_cnt_reg  <= '0;
               filt_reg     <= 1'b0;
               rise_reg     <= 1'b0;
               fall_reg     <= 1'b0;
               hold_cnt_reg <= '0;
               held_reg     <= 1'b0;
               long_reg     <= 1'b0;
            end else begin
               deb_cnt_reg  <= deb_cnt_next;
               filt_reg     <= filt_next;
               rise_reg     <= rise_next;
               fall_reg     <= fall_next;
               hold_cnt_reg <= hold_cnt_next;
               held_reg     <= held_next;
               long_reg     <= long_next;
            end
         end

         assign o_filtered[gi] = filt_reg;
         assign o_rise[gi]     = rise_reg;
         assign o_fall[gi]     = fall_reg;
         assign o_held[gi]     = held_reg;
         assign o_long[gi]     = long_reg;
      end
   endgenerate

   assign o_any_event = |(o_rise | o_fall);

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: table of vectors, directed corner sequences and random
// stimulus checked against a window/edge-count reference model.
module tb_debounce_bank;

   localparam int CH = 2;
   localparam int DL = 4;
   localparam int SS = 2;
   localparam int HL = 8;

   logic          clk = 1'b0;
   logic          i_reset = 1'b1;
   logic [CH-1:0] i_switch = '0;
   logic [CH-1:0] o_filtered, o_rise, o_fall, o_held, o_long;
   logic          o_any_event;

   debounce_bank #(
      .CHANNELS(CH), .DEBOUNCE_LIMIT(DL), .SYNC_STAGES(SS), .HOLD_LIMIT(HL)
   ) dut (
      .i_clock(clk), .i_reset(i_reset), .i_switch(i_switch),
      .o_filtered(o_filtered), .o_rise(o_rise), .o_fall(o_fall),
      .o_held(o_held), .o_long(o_long), .o_any_event(o_any_event)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_no = 0;

   // Reference model: raw input history plus edge index of the last accepted rise.
   logic [CH-1:0] raw_q[$];
   logic [CH-1:0] m_filt, m_rise, m_fall, m_held, m_long;
   int            rise_edge[CH];

   typedef struct packed {
      logic          rst;
      logic [CH-1:0] sw;
      logic [10:0]   exp;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic rst, input logic [1:0] sw, input logic [1:0] filt,
                               input logic [1:0] rise, input logic [1:0] fall,
                               input logic [1:0] held, input logic [1:0] lng);
      vec_t v;
      v.rst = rst;
      v.sw  = sw;
      v.exp = {filt, rise, fall, held, lng, |(rise | fall)};
      return v;
   endfunction

   function automatic logic [10:0] dut_vec();
      return {o_filtered, o_rise, o_fall, o_held, o_long, o_any_event};
   endfunction

   function automatic logic [10:0] model_vec();
      return {m_filt, m_rise, m_fall, m_held, m_long, |(m_rise | m_fall)};
   endfunction

   // A level is accepted once the synchronised input (raw delayed SS edges) has
   // shown the same new value for DL consecutive edges.
   function automatic void model_edge(input logic rst, input logic [CH-1:0] sw);
      int   base;
      logic v;
      logic stable;
      edge_no++;
      m_rise = '0;
      m_fall = '0;
      m_long = '0;
      if (rst) begin
         raw_q.delete();
         for (int i = 0; i < SS + DL; i++) raw_q.push_back('0);
         m_filt = '0;
         m_held = '0;
         for (int c = 0; c < CH; c++) rise_edge[c] = 0;
      end else begin
         raw_q.push_back(sw);
         base = raw_q.size() - 1 - SS;
         for (int c = 0; c < CH; c++) begin
            v = raw_q[base][c];
            stable = 1'b1;
            for (int i = 1; i < DL; i++) begin
               if (raw_q[base - i][c] != v) stable = 1'b0;
            end
            if (stable && (v != m_filt[c])) begin
               m_filt[c] = v;
               if (v) begin
                  m_rise[c] = 1'b1;
                  rise_edge[c] = edge_no;
               end else begin
                  m_fall[c] = 1'b1;
               end
            end
            m_long[c] = m_filt[c] && ((edge_no - rise_edge[c]) == HL);
            m_held[c] = m_filt[c] && ((edge_no - rise_edge[c]) >= HL);
         end
         while (raw_q.size() > SS + DL) void'(raw_q.pop_front());
      end
   endfunction

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_no, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic [CH-1:0] sw);
      @(negedge clk);
      i_reset  = rst;
      i_switch = sw;
      @(posedge clk);
      #1;
      model_edge(rst, sw);
      check_val("model", {21'd0, dut_vec()}, {21'd0, model_vec()});
      $display("edge %0d rst=%b sw=%b filt=%b rise=%b fall=%b held=%b long=%b any=%b",
               edge_no, rst, sw, o_filtered, o_rise, o_fall, o_held, o_long, o_any_event);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int any_cnt;
      int pat[8];
      logic [CH-1:0] sw;

      // Clean press on channel 0 straight after reset.
      tbl[0] = mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      for (int i = 1; i < 16; i++) begin
         tbl[i] = mk(1'b0, 2'b01,
                     (i >= 6)  ? 2'b01 : 2'b00,
                     (i == 6)  ? 2'b01 : 2'b00,
                     2'b00,
                     (i >= 14) ? 2'b01 : 2'b00,
                     (i == 14) ? 2'b01 : 2'b00);
      end
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].rst, tbl[i].sw);
         check_val("table", {21'd0, dut_vec()}, {21'd0, tbl[i].exp});
      end

      // Long-press release: fall and held-clear on the same edge, one event pulse.
      any_cnt = 0;
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 2'b00);
         if (k == 5) check_val("lrel_held_before", o_held[0], 1);
         if (k == 6) begin
            check_val("lrel_fall", o_fall[0], 1);
            check_val("lrel_held_clr", o_held[0], 0);
         end
         any_cnt += o_any_event;
      end
      check_val("lrel_any_once", any_cnt, 1);

      // Glitch of three cycles is rejected.
      for (int k = 1; k <= 11; k++) begin
         step(1'b0, (k <= 3) ? 2'b01 : 2'b00);
         check_val("glitch", {o_filtered, o_rise, o_any_event}, 0);
      end

      // Stable press accepted, then a short press released before the hold limit.
      for (int k = 1; k <= 6; k++) begin
         step(1'b0, 2'b01);
         check_val("accept_rise", o_rise[0], (k == 6));
      end
      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 2'b00);
         check_val("short_rel", {o_fall[0], o_held[0], o_long[0]}, {(k == 6), 1'b0, 1'b0});
      end

      // Chatter on channel 1 restarts the count.
      pat = '{1, 1, 1, 0, 1, 1, 1, 1};
      for (int k = 1; k <= 12; k++) begin
         sw = '0;
         sw[1] = (k <= 8) ? pat[k-1][0] : 1'b1;
         step(1'b0, sw);
         check_val("chatter_rise", o_rise[1], (k == 10));
      end

      // Reset while channel 0 counts up and channel 1 counts down mid-hold.
      for (int k = 1; k <= 3; k++) step(1'b0, 2'b01);
      step(1'b1, 2'b11);
      check_val("reset_mid", {21'd0, dut_vec()}, 0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 2'b11);
         check_val("post_reset_rise", o_rise, (k == 6) ? 2'b11 : 2'b00);
         check_val("post_reset_any", o_any_event, (k == 6));
      end

      // Random slowly-changing stimulus with occasional resets.
      sw = 2'b11;
      for (int n = 0; n < 800; n++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 9) == 0) sw[c] = ~sw[c];
         end
         step(($urandom_range(0, 299) == 0), sw);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
